// File: rtl/clause_stream_parser_pkg.sv
// Shared token and parser-state definitions for the clause stream parser.
package clause_stream_parser_pkg;

    localparam int TOKEN_W   = 16;
    localparam int FLAG_W    = 3;
    localparam int PAYLOAD_W = TOKEN_W - FLAG_W;

    // 011 and 100 are deliberately absent: they are illegal on the wire.
    typedef enum logic [FLAG_W-1:0] {
        FLAG_END_BOARD   = 3'b000,
        FLAG_END_LINE    = 3'b001,
        FLAG_OR          = 3'b010,
        FLAG_AND         = 3'b101,
        FLAG_START_LINE  = 3'b110,
        FLAG_START_BOARD = 3'b111
    } token_flag_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BOARD = 3'd1;
    localparam logic [2:0] ST_LINE  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/clause_stream_parser_token_assembler.sv
// Pairs accepted bytes into {flag, payload} tokens; tok_valid pulses with the completing byte.
module clause_stream_parser_token_assembler
    import clause_stream_parser_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           byte_in,
    input  logic                 accept,
    output logic                 tok_valid,
    output logic [FLAG_W-1:0]    flag,
    output logic [PAYLOAD_W-1:0] payload
);

    logic       phase;
    logic [7:0] first_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= 1'b0;
        end else if (accept) begin
            phase <= !phase;
        end
    end

    // Data-only register: a reset drops the phase, so a stale first byte is never paired.
    always_ff @(posedge clk) begin
        if (accept && !phase) begin
            first_byte <= byte_in;
        end
    end

    assign tok_valid = accept && phase;
    assign flag      = first_byte[7:5];
    assign payload   = {first_byte[4:0], byte_in};

endmodule

// File: rtl/clause_stream_parser.sv
// Walks the board/line/option/term token grammar and emits literal writes to the clause BRAM.
module clause_stream_parser
    import clause_stream_parser_pkg::*;
#(
    parameter int DIM_W    = 6,
    parameter int LINE_W   = 7,
    parameter int OPT_W    = 4,
    parameter int TERM_W   = 4,
    parameter int ASSIGN_W = 13
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       byte_in,
    input  logic                             valid_in,
    output logic                             ready_out,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [LINE_W+OPT_W+TERM_W-1:0]   wr_addr,
    output logic [ASSIGN_W-1:0]              wr_data,
    output logic                             line_done,
    output logic [OPT_W:0]                   line_opts,
    output logic [DIM_W-1:0]                 n,
    output logic [DIM_W-1:0]                 m,
    output logic                             board_done,
    output logic                             err
);

    localparam int LT_W = LINE_W + 1;
    localparam int TM_W = TERM_W + 1;
    localparam int OC_W = OPT_W + 1;

    logic                 accept;
    logic                 tok_valid;
    logic [FLAG_W-1:0]    tok_flag;
    logic [PAYLOAD_W-1:0] tok_payload;

    logic [2:0]        state;
    logic [LINE_W-1:0] line;
    logic [OPT_W-1:0]  opt;
    logic [TM_W-1:0]   term;

    logic [DIM_W-1:0]  new_n;
    logic [DIM_W-1:0]  new_m;
    logic              dims_zero;
    logic              line_full;

    assign ready_out = !(wr_valid && !wr_ready) && (state != ST_DONE);
    assign accept    = valid_in && ready_out;

    clause_stream_parser_token_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .accept    (accept),
        .tok_valid (tok_valid),
        .flag      (tok_flag),
        .payload   (tok_payload)
    );

    assign new_n     = tok_payload[2*DIM_W-1 -: DIM_W];
    assign new_m     = tok_payload[DIM_W-1:0];
    assign dims_zero = (new_n == '0) || (new_m == '0);
    assign line_full = ({1'b0, line} == (LT_W'(n) + LT_W'(m)));

    // term is one bit wider than the address field so that 2**TERM_W is representable and caught.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            line       <= '0;
            opt        <= '0;
            term       <= '0;
            n          <= '0;
            m          <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            line_done  <= 1'b0;
            line_opts  <= '0;
            board_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (wr_valid && wr_ready) begin
                wr_valid <= 1'b0;
            end
            if (tok_valid) begin
                case (state)
                    ST_IDLE, ST_ERROR: begin
                        if (tok_flag == FLAG_START_BOARD && !dims_zero) begin
                            n          <= new_n;
                            m          <= new_m;
                            line       <= '0;
                            opt        <= '0;
                            term       <= '0;
                            err        <= 1'b0;
                            board_done <= 1'b0;
                            state      <= ST_BOARD;
                        end else if (state == ST_IDLE || tok_flag == FLAG_START_BOARD) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end
                    end
                    ST_BOARD: begin
                        case (tok_flag)
                            FLAG_START_LINE: begin
                                if (line_full) begin
                                    err   <= 1'b1;
                                    state <= ST_ERROR;
                                end else begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= {line, {OPT_W{1'b0}}, {TERM_W{1'b0}}};
                                    wr_data  <= tok_payload[ASSIGN_W-1:0];
                                    opt      <= '0;
                                    term     <= TM_W'(1);
                                    state    <= ST_LINE;
                                end
                            end
                            FLAG_END_BOARD: begin
                                if (line_full) begin
                                    board_done <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                                state <= ST_DONE;
                            end
                            default: begin
                                err   <= 1'b1;
                                state <= ST_ERROR;
                            end
                        endcase
                    end
                    ST_LINE: begin
                        case (tok_flag)
                            FLAG_AND: begin
                                if (term[TERM_W]) begin
                                    err   <= 1'b1;
                                    state <= ST_ERROR;
                                end else begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= {line, opt, term[TERM_W-1:0]};
                                    wr_data  <= tok_payload[ASSIGN_W-1:0];
                                    term     <= term + TM_W'(1);
                                end
                            end
                            FLAG_OR: begin
                                if (&opt) begin
                                    err   <= 1'b1;
                                    state <= ST_ERROR;
                                end else begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= {line, opt + OPT_W'(1), {TERM_W{1'b0}}};
                                    wr_data  <= tok_payload[ASSIGN_W-1:0];
                                    opt      <= opt + OPT_W'(1);
                                    term     <= TM_W'(1);
                                end
                            end
                            FLAG_END_LINE: begin
                                line_done <= 1'b1;
                                line_opts <= {1'b0, opt} + OC_W'(1);
                                line      <= line + LINE_W'(1);
                                state     <= ST_BOARD;
                            end
                            default: begin
                                err   <= 1'b1;
                                state <= ST_ERROR;
                            end
                        endcase
                    end
                    ST_DONE: begin
                    end
                    default: begin
                        err   <= 1'b1;
                        state <= ST_ERROR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clause_stream_parser.sv
// Directed bench for clause_stream_parser with a write/line_done scoreboard.
module tb_clause_stream_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [14:0] wr_addr;
    logic [12:0] wr_data;
    logic        line_done;
    logic [4:0]  line_opts;
    logic [5:0]  n;
    logic [5:0]  m;
    logic        board_done;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [14:0] addr;
        logic [12:0] data;
    } wexp_t;

    wexp_t      wq[$];
    logic [4:0] lq[$];
    wexp_t      wcur;

    clause_stream_parser dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .line_done  (line_done),
        .line_opts  (line_opts),
        .n          (n),
        .m          (m),
        .board_done (board_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wr_valid && wr_ready) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", 32'(wr_valid), 32'd0);
            end else begin
                wcur = wq.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(wcur.addr));
                check("wr_data", 32'(wr_data), 32'(wcur.data));
            end
        end
        if (rst && line_done) begin
            if (lq.size() == 0) begin
                check("line_done_unexpected", 32'(line_done), 32'd0);
            end else begin
                check("line_opts", 32'(line_opts), 32'(lq.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        byte_in  = b;
        valid_in = 1'b1;
        while (!ready_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready_out) begin
            check("byte_accept", 32'(ready_out), 32'd1);
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic tok(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic expect_w(input int l, input int o, input int t, input int d);
        wexp_t e;
        e.addr = 15'((l << 8) | (o << 4) | t);
        e.data = 13'(d);
        wq.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((wq.size() != 0 || lq.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(wq.size() + lq.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        wr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset mid-token discards the half-assembled token
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_byte(8'hE0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_line_opts", 32'(line_opts), 32'd0);
        check("rst_n", 32'(n), 32'd0);
        check("rst_m", 32'(m), 32'd0);
        check("rst_board_done", 32'(board_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tok(8'hE0, 8'h41);
        @(negedge clk);
        check("t1_n", 32'(n), 32'd1);
        check("t1_m", 32'(m), 32'd1);
        check("t1_err", 32'(err), 32'd0);

        // 2x2 board, one literal per line
        do_reset();
        tok(8'hE0, 8'h82);
        @(negedge clk);
        check("t2_n", 32'(n), 32'd2);
        check("t2_m", 32'(m), 32'd2);
        for (int i = 0; i < 4; i++) begin
            expect_w(i, 0, 0, i + 3);
            lq.push_back(5'd1);
            tok(8'hC0, 8'(i + 3));
            tok(8'h20, 8'h00);
        end
        tok(8'h00, 8'h00);
        wait_drain();
        @(negedge clk);
        check("t2_board_done", 32'(board_done), 32'd1);
        check("t2_err", 32'(err), 32'd0);
        check("t2_done_ready", 32'(ready_out), 32'd0);

        // AND / OR sequencing within one line
        do_reset();
        tok(8'hE0, 8'h82);
        expect_w(0, 0, 0, 5);
        tok(8'hC0, 8'h05);
        expect_w(0, 0, 1, 6);
        tok(8'hA0, 8'h06);
        expect_w(0, 1, 0, 7);
        tok(8'h40, 8'h07);
        lq.push_back(5'd2);
        tok(8'h20, 8'h00);
        wait_drain();
        check("t3_err", 32'(err), 32'd0);

        // Backpressure: write held while wr_ready is low
        do_reset();
        tok(8'hE0, 8'h82);
        @(posedge clk);
        #1 wr_ready = 1'b0;
        expect_w(0, 0, 0, 'h15);
        tok(8'hC0, 8'h15);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_ready_low", 32'(ready_out), 32'd0);
            check("t4_wr_valid_held", 32'(wr_valid), 32'd1);
            check("t4_addr_stable", 32'(wr_addr), 32'd0);
            check("t4_data_stable", 32'(wr_data), 32'h15);
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        expect_w(0, 0, 1, 'h16);
        tok(8'hA0, 8'h16);
        lq.push_back(5'd1);
        tok(8'h20, 8'h00);
        wait_drain();
        check("t4_err", 32'(err), 32'd0);

        // Grammar errors and recovery through START_BOARD
        do_reset();
        tok(8'hE0, 8'h82);
        tok(8'hA0, 8'h01);
        @(negedge clk);
        check("t5_and_in_board_err", 32'(err), 32'd1);
        check("t5_and_in_board_nowr", 32'(wr_valid), 32'd0);
        tok(8'hE0, 8'h41);
        @(negedge clk);
        check("t5_recover_err", 32'(err), 32'd0);
        expect_w(0, 0, 0, 9);
        tok(8'hC0, 8'h09);
        tok(8'h60, 8'h00);
        @(negedge clk);
        check("t5_flag011_err", 32'(err), 32'd1);
        check("t5_flag011_nowr", 32'(wr_valid), 32'd0);
        tok(8'hE0, 8'h41);
        expect_w(0, 0, 0, 'h0A);
        tok(8'hC0, 8'h0A);
        lq.push_back(5'd1);
        tok(8'h20, 8'h00);
        expect_w(1, 0, 0, 'h0B);
        tok(8'hC0, 8'h0B);
        lq.push_back(5'd1);
        tok(8'h20, 8'h00);
        tok(8'h00, 8'h00);
        wait_drain();
        @(negedge clk);
        check("t5_board_done", 32'(board_done), 32'd1);
        check("t5_err_final", 32'(err), 32'd0);

        // END_BOARD with a missing line
        do_reset();
        tok(8'hE0, 8'h82);
        for (int i = 0; i < 3; i++) begin
            expect_w(i, 0, 0, 1);
            lq.push_back(5'd1);
            tok(8'hC0, 8'h01);
            tok(8'h20, 8'h00);
        end
        tok(8'h00, 8'h00);
        wait_drain();
        @(negedge clk);
        check("t6_short_err", 32'(err), 32'd1);
        check("t6_short_board_done", 32'(board_done), 32'd0);
        check("t6_short_ready", 32'(ready_out), 32'd0);

        // Term overflow: START_LINE literal plus 15 ANDs fill the line
        do_reset();
        tok(8'hE0, 8'h82);
        expect_w(0, 0, 0, 0);
        tok(8'hC0, 8'h00);
        for (int t = 1; t < 16; t++) begin
            expect_w(0, 0, t, t);
            tok(8'hA0, 8'(t));
        end
        @(negedge clk);
        check("t6_terms_ok", 32'(err), 32'd0);
        tok(8'hA0, 8'hFF);
        @(negedge clk);
        check("t6_term_ovf_err", 32'(err), 32'd1);
        check("t6_term_ovf_nowr", 32'(wr_valid), 32'd0);
        wait_drain();

        // Option overflow
        do_reset();
        tok(8'hE0, 8'h82);
        expect_w(0, 0, 0, 0);
        tok(8'hC0, 8'h00);
        for (int o = 1; o < 16; o++) begin
            expect_w(0, o, 0, o + 32);
            tok(8'h40, 8'(o + 32));
        end
        @(negedge clk);
        check("t6_opts_ok", 32'(err), 32'd0);
        tok(8'h40, 8'h01);
        @(negedge clk);
        check("t6_opt_ovf_err", 32'(err), 32'd1);
        check("t6_opt_ovf_nowr", 32'(wr_valid), 32'd0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
